dso_capture: RTL and testbench
==============================

DSO_CAPTURE -- requirements
Module: dso_capture

Interface
REQ-001 Parameter DW, default 8: ADC sample width in bits.
REQ-002 Parameter AW, default 10: buffer address width; DEPTH = 2**AW = 1024 samples.
REQ-003 Parameter PRE, default 512: pre-trigger sample count; legal range 1..DEPTH-1.
REQ-004 clock  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 sample_clk  in  1  timebase sample clock, registered in the clock domain; each 0->1 transition requests one sample.
REQ-007 adc_data  in  DW  ADC sample, valid whenever sample_clk rises.
REQ-008 trig_level  in  DW  unsigned trigger threshold.
REQ-009 trig_edge  in  1  trigger slope: 0 = rising, 1 = falling.
REQ-010 force_trig  in  1  level; while high in WAIT_TRIG, the next sample triggers unconditionally.
REQ-011 arm  in  1  single-cycle pulse that starts a capture.
REQ-012 rd_addr  in  AW  read offset relative to record start.
REQ-013 rd_data  out  DW  sample at rd_addr; 1-cycle read latency.
REQ-014 busy  out  1  high from PRE_FILL through POST_FILL.
REQ-015 done  out  1  high in DONE; record is stable and readable.

Function
REQ-016 Sample strobe: strobe = sample_clk AND NOT sample_clk_d; sample_clk_d is sample_clk delayed one clock. Exactly one strobe per rising edge.
REQ-017 States: IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, DONE.
REQ-018 IDLE or DONE, arm=1 -> PRE_FILL next cycle; wr_ptr <- 0, cnt <- 0, done <- 0.
REQ-019 arm is ignored in PRE_FILL, WAIT_TRIG and POST_FILL.
REQ-020 In PRE_FILL, WAIT_TRIG and POST_FILL, each strobe writes adc_data to mem[wr_ptr]. wr_ptr increments mod DEPTH. prev_sample <- adc_data.
REQ-021 PRE_FILL -> WAIT_TRIG on the strobe that writes the PRE-th sample.
REQ-022 WAIT_TRIG trigger, evaluated on the strobe only. Rising: prev_sample < trig_level AND adc_data >= trig_level. Falling: prev_sample > trig_level AND adc_data <= trig_level. force_trig=1 also triggers.
REQ-023 On trigger: trig_ptr <- wr_ptr (address of the triggering sample); the sample is written; cnt <- 0; -> POST_FILL.
REQ-024 POST_FILL writes DEPTH-PRE-1 further samples, then -> DONE on the strobe of the last write.
REQ-025 start_ptr = (trig_ptr - PRE) mod DEPTH, AW-bit wrap arithmetic. The triggering sample sits at record offset PRE.
REQ-026 rd_data <= mem[(start_ptr + rd_addr) mod DEPTH], registered, one cycle after rd_addr. Reads are allowed in any state. Content is defined only when done=1.
REQ-027 No memory writes occur in IDLE or DONE. A strobe and a read in the same cycle do not interfere (dual-port).
REQ-028 WAIT_TRIG has no timeout; it overwrites the buffer circularly until a trigger arrives.
REQ-029 busy = (state is PRE_FILL, WAIT_TRIG or POST_FILL), registered with the state.

Reset
REQ-030 reset=0 at a clock edge -> state IDLE; wr_ptr, trig_ptr, cnt, prev_sample, sample_clk_d and rd_data all 0; busy=0, done=0.
REQ-031 Reset mid-capture abandons the record. Memory contents are not cleared and are undefined afterwards.

Structure
REQ-032 A shared package dso_pkg holds the state encoding and the default DW, AW and PRE constants.
REQ-033 Storage is one sub-module, dso_sample_ram: simple dual-port, DEPTH x DW, one synchronous write port and one registered read port.

Verification
REQ-034 Test 1. Stimulus: ramp adc_data = n mod 256 per strobe, trig_level=100, trig_edge=0, arm. Response: trigger at sample n=612, trig_ptr=612, start_ptr=100. After done, rd_addr 0 -> 100, rd_addr 512 -> 100, rd_addr 1023 -> 99.
REQ-035 Test 2. Stimulus: falling edge, adc_data constant 200 then step to 50, trig_level=128. Response: the trigger occurs at the step sample, and rd_addr 512 reads 50 while rd_addr 511 reads 200.
REQ-036 Test 3. Stimulus: constant adc_data=10, trig_level=100, force_trig raised after 700 strobes. Response: the next strobe triggers, and done asserts exactly 511 strobes later.
REQ-037 Test 4. Stimulus: sample_clk held high for 5 clocks, then a second arm pulse during busy. Response: one sample per rising edge only; the second arm is ignored and state is unchanged.
REQ-038 Test 5. Stimulus: reset=0 during POST_FILL. Response: next cycle state IDLE, busy=0, done=0. A subsequent arm runs a full capture correctly.

Source files
------------

// File: rtl/dso_pkg.sv
// Shared state encoding and default geometry for the DSO capture block.
package dso_pkg;

  localparam int unsigned DefaultDw  = 8;
  localparam int unsigned DefaultAw  = 10;
  localparam int unsigned DefaultPre = 512;

  typedef enum logic [2:0] {
    StIdle,
    StPreFill,
    StWaitTrig,
    StPostFill,
    StDone
  } dso_state_e;

endpackage

// File: rtl/dso_capture_if.sv
// Acquisition, trigger, readback and status signals of the DSO capture block.
interface dso_capture_if import dso_pkg::*; #(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned AW = DefaultAw
) ();

  logic          sample_clk;
  logic [DW-1:0] adc_data;
  logic [DW-1:0] trig_level;
  logic          trig_edge;
  logic          force_trig;
  logic          arm;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;

  modport master (
    output sample_clk, adc_data, trig_level, trig_edge, force_trig, arm, rd_addr,
    input  rd_data, busy, done
  );

  modport slave (
    input  sample_clk, adc_data, trig_level, trig_edge, force_trig, arm, rd_addr,
    output rd_data, busy, done
  );

endinterface

// File: rtl/dso_sample_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read.
module dso_sample_ram #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dso_capture.sv
// Triggered single-shot capture into a circular buffer with pre-trigger history.
module dso_capture import dso_pkg::*; #(
  parameter int unsigned DW  = DefaultDw,
  parameter int unsigned AW  = DefaultAw,
  parameter int unsigned PRE = DefaultPre
) (
  input logic          clock,
  input logic          reset,
  dso_capture_if.slave bus
);

  localparam int unsigned Depth    = 2 ** AW;
  localparam int unsigned PostLen  = Depth - PRE - 1;
  localparam logic [AW-1:0] PreLast  = AW'(PRE - 1);
  localparam logic [AW-1:0] PostLast = AW'(PostLen - 1);

  dso_state_e    state_q, state_d;
  logic          sample_clk_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          busy_q, done_q;

  logic          strobe;
  logic          capturing;
  logic          hit;
  logic          trig;
  logic          we;
  logic [AW-1:0] start_ptr;
  logic [AW-1:0] raddr;

  assign strobe    = bus.sample_clk & ~sample_clk_q;
  assign capturing = (state_q == StPreFill) || (state_q == StWaitTrig) ||
                     (state_q == StPostFill);
  assign start_ptr = trig_ptr_q - AW'(PRE);
  assign raddr     = start_ptr + bus.rd_addr;

  always_comb begin
    hit = 1'b0;
    if (bus.trig_edge) begin
      hit = (prev_q > bus.trig_level) && (bus.adc_data <= bus.trig_level);
    end else begin
      hit = (prev_q < bus.trig_level) && (bus.adc_data >= bus.trig_level);
    end
    trig = hit | bus.force_trig;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    we         = 1'b0;

    if (capturing && strobe) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      prev_d   = bus.adc_data;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.arm) begin
          state_d  = StPreFill;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      StPreFill: begin
        if (strobe) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PreLast) begin
            state_d = StWaitTrig;
            cnt_d   = '0;
          end
        end
      end
      StWaitTrig: begin
        if (strobe && trig) begin
          trig_ptr_d = wr_ptr_q;
          cnt_d      = '0;
          state_d    = (PostLen == 0) ? StDone : StPostFill;
        end
      end
      StPostFill: begin
        if (strobe) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PostLast) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      sample_clk_q <= 1'b0;
      wr_ptr_q     <= '0;
      trig_ptr_q   <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_clk_q <= bus.sample_clk;
      wr_ptr_q     <= wr_ptr_d;
      trig_ptr_q   <= trig_ptr_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      busy_q       <= (state_d == StPreFill) || (state_d == StWaitTrig) ||
                      (state_d == StPostFill);
      done_q       <= (state_d == StDone);
    end
  end

  dso_sample_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clock(clock),
    .reset(reset),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata(bus.adc_data),
    .raddr(raddr),
    .rdata(bus.rd_data)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_dso_capture.sv
// Directed bench for dso_capture: edge/force triggers, strobe detection, re-arm and reset.
module tb_dso_capture;
  import dso_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  dso_capture_if #(.DW(8), .AW(10)) bus ();

  dso_capture #(
    .DW (8),
    .AW (10),
    .PRE(512)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample(input logic [7:0] v);
    @(negedge clock);
    bus.adc_data   = v;
    bus.sample_clk = 1'b1;
    @(negedge clock);
    bus.sample_clk = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_arm();
    @(negedge clock);
    bus.arm = 1'b1;
    @(negedge clock);
    bus.arm = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [9:0] addr, input logic [7:0] exp);
    @(negedge clock);
    bus.rd_addr = addr;
    @(negedge clock);
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  // Ramp capture until done; returns the number of samples fed.
  task automatic ramp_capture(output int n);
    n = 0;
    while (!bus.done && n < 3000) begin
      sample(8'(n % 256));
      n++;
    end
  endtask

  int n;

  initial begin
    bus.sample_clk = 1'b0;
    bus.adc_data   = '0;
    bus.trig_level = 8'd100;
    bus.trig_edge  = 1'b0;
    bus.force_trig = 1'b0;
    bus.arm        = 1'b0;
    bus.rd_addr    = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    reset = 1'b1;
    @(negedge clock);

    // Test 1: rising ramp trigger at n=612, done after 511 post samples
    pulse_arm();
    check("t1_busy_after_arm", 32'(bus.busy), 1);
    ramp_capture(n);
    check("t1_len", 32'(n), 1124);
    check("t1_done", 32'(bus.done), 1);
    check("t1_busy_done", 32'(bus.busy), 0);
    read_chk("t1_rd0", 10'd0, 8'd100);
    read_chk("t1_rd512", 10'd512, 8'd100);
    read_chk("t1_rd1023", 10'd1023, 8'd99);
    read_chk("t1_rd511", 10'd511, 8'd99);

    // Test 2: falling edge, 600 samples of 200 then a step to 50
    bus.trig_edge  = 1'b1;
    bus.trig_level = 8'd128;
    pulse_arm();
    check("t2_done_clr", 32'(bus.done), 0);
    for (int i = 0; i < 600; i++) sample(8'd200);
    check("t2_no_trig_busy", 32'(bus.busy), 1);
    for (int i = 0; i < 511; i++) sample(8'd50);
    check("t2_done_early", 32'(bus.done), 0);
    sample(8'd50);
    check("t2_done", 32'(bus.done), 1);
    read_chk("t2_rd512", 10'd512, 8'd50);
    read_chk("t2_rd511", 10'd511, 8'd200);
    read_chk("t2_rd0", 10'd0, 8'd200);
    read_chk("t2_rd1023", 10'd1023, 8'd50);

    // Test 3: no crossing; force after 700 strobes
    bus.trig_edge  = 1'b0;
    bus.trig_level = 8'd100;
    pulse_arm();
    for (int i = 0; i < 700; i++) sample(8'd10);
    check("t3_wait_busy", 32'(bus.busy), 1);
    check("t3_wait_done", 32'(bus.done), 0);
    bus.force_trig = 1'b1;
    sample(8'd10);
    bus.force_trig = 1'b0;
    for (int i = 0; i < 510; i++) sample(8'd10);
    check("t3_done_510", 32'(bus.done), 0);
    sample(8'd10);
    check("t3_done_511", 32'(bus.done), 1);
    read_chk("t3_rd512", 10'd512, 8'd10);

    // Test 4: held sample_clk gives one sample; arm during busy ignored
    bus.force_trig = 1'b1;
    pulse_arm();
    @(negedge clock);
    bus.adc_data   = 8'd55;
    bus.sample_clk = 1'b1;
    repeat (2) @(negedge clock);
    bus.adc_data = 8'd66;
    repeat (3) @(negedge clock);
    bus.sample_clk = 1'b0;
    @(negedge clock);
    for (int k = 1; k < 1023; k++) begin
      sample(8'(k % 256));
      if (k == 10) begin
        pulse_arm();
        check("t4_busy_rearm", 32'(bus.busy), 1);
        check("t4_done_rearm", 32'(bus.done), 0);
      end
    end
    check("t4_done_1023", 32'(bus.done), 0);
    sample(8'd255);
    check("t4_done_1024", 32'(bus.done), 1);
    bus.force_trig = 1'b0;
    read_chk("t4_rd0", 10'd0, 8'd55);
    read_chk("t4_rd1", 10'd1, 8'd1);
    read_chk("t4_rd2", 10'd2, 8'd2);
    read_chk("t4_rd512", 10'd512, 8'd0);
    read_chk("t4_rd1023", 10'd1023, 8'd255);

    // Test 5: reset during POST_FILL, then a clean capture
    pulse_arm();
    for (int i = 0; i < 700; i++) sample(8'(i % 256));
    check("t5_post_busy", 32'(bus.busy), 1);
    reset = 1'b0;
    @(negedge clock);
    check("t5_rst_busy", 32'(bus.busy), 0);
    check("t5_rst_done", 32'(bus.done), 0);
    check("t5_rst_rd_data", 32'(bus.rd_data), 0);
    reset = 1'b1;
    @(negedge clock);
    pulse_arm();
    check("t5_busy_after_arm", 32'(bus.busy), 1);
    ramp_capture(n);
    check("t5_len", 32'(n), 1124);
    read_chk("t5_rd0", 10'd0, 8'd100);
    read_chk("t5_rd512", 10'd512, 8'd100);
    read_chk("t5_rd1023", 10'd1023, 8'd99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
